// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared flag and occupancy types for the ALU result stage
package alu_pkg;

  localparam int FLAG_C = 0;
  localparam int FLAG_V = 1;
  localparam int FLAG_Z = 2;
  localparam int FLAG_N = 3;

  typedef struct packed {
    logic n;
    logic z;
    logic v;
    logic c;
  } alu_flags_t;

  typedef enum logic [1:0] {
    OCC_EMPTY   = 2'd0,
    OCC_PARTIAL = 2'd1,
    OCC_FULL    = 2'd2
  } occ_state_t;

endpackage

// File: rtl/result_fifo.sv
// rtl/result_fifo.sv - DEPTH-entry valid/ready FIFO with occupancy FSM and held head output
module result_fifo
  import alu_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_valid,
  output logic              push_ready,
  input  logic [DATA_W-1:0] push_data,
  output logic              pop_valid,
  input  logic              pop_ready,
  output logic [DATA_W-1:0] pop_data
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  occ_state_t        state_q;
  occ_state_t        state_d;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  count_d;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] hold_q;
  logic              push;
  logic              pop;

  // Ready depends only on registered state, never on pop_ready.
  assign push_ready = (state_q != OCC_FULL);
  assign pop_valid  = (state_q == OCC_PARTIAL) || (state_q == OCC_FULL);
  assign push       = push_valid && push_ready;
  assign pop        = pop_valid && pop_ready;
  assign pop_data   = pop_valid ? mem[rd_ptr] : hold_q;

  always_comb begin
    count_d = count_q;
    state_d = state_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    case (state_q)
      OCC_EMPTY: begin
        if (push) state_d = OCC_PARTIAL;
      end
      OCC_PARTIAL: begin
        if (push && !pop && (count_q == CNT_W'(DEPTH - 1))) state_d = OCC_FULL;
        else if (pop && !push && (count_q == CNT_W'(1)))    state_d = OCC_EMPTY;
      end
      OCC_FULL: begin
        if (pop) state_d = OCC_PARTIAL;
      end
      default: state_d = OCC_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= OCC_EMPTY;
      count_q <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        hold_q <= mem[rd_ptr];
      end
    end
  end

  // Storage needs no reset: it is only visible through pop_valid or hold_q.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/alu_result_stage.sv
// rtl/alu_result_stage.sv - registered ALU result stage: FIFO, NZVC flags, overflow status
// Optional ALU_RESULT_SAT_EN: saturate stored result on signed overflow.
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int DEPTH     = 2,
  parameter int OVF_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_result,
  input  logic                 in_cout,
  input  logic                 in_ovf,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_result,
  output logic [3:0]           out_flags,
  output logic                 ovf_sticky,
  output logic [OVF_CNT_W-1:0] ovf_count,
  input  logic                 clr_sticky
);

  localparam int ENTRY_W = WIDTH + 4;

  logic [WIDTH-1:0]   stored_result;
  alu_flags_t         entry_flags;
  alu_flags_t         head_flags;
  logic [ENTRY_W-1:0] push_entry;
  logic [ENTRY_W-1:0] head_entry;
  logic               push;

`ifdef ALU_RESULT_SAT_EN
  localparam logic [WIDTH-1:0] SIGNED_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SIGNED_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  // A wrapped result with the sign bit set came from a positive overflow.
  always_comb begin
    stored_result = in_result;
    if (in_ovf) stored_result = in_result[WIDTH-1] ? SIGNED_MAX : SIGNED_MIN;
  end
`else
  assign stored_result = in_result;
`endif

  always_comb begin
    entry_flags   = '0;
    entry_flags.n = stored_result[WIDTH-1];
    entry_flags.z = (stored_result == '0);
    entry_flags.v = in_ovf;
    entry_flags.c = in_cout;
  end

  assign push_entry = {entry_flags, stored_result};
  assign push       = in_valid && in_ready;

  result_fifo #(
    .DATA_W (ENTRY_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_valid (in_valid),
    .push_ready (in_ready),
    .push_data  (push_entry),
    .pop_valid  (out_valid),
    .pop_ready  (out_ready),
    .pop_data   (head_entry)
  );

  assign head_flags = alu_flags_t'(head_entry[ENTRY_W-1:WIDTH]);
  assign out_result = head_entry[WIDTH-1:0];
  assign out_flags  = head_flags;

  // An overflow push outranks a same-cycle clear, restarting the count at one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_sticky <= 1'b0;
      ovf_count  <= '0;
    end else if (push && in_ovf) begin
      ovf_sticky <= 1'b1;
      if (clr_sticky)        ovf_count <= OVF_CNT_W'(1);
      else if (~&ovf_count)  ovf_count <= ovf_count + 1'b1;
    end else if (clr_sticky) begin
      ovf_sticky <= 1'b0;
      ovf_count  <= '0;
    end
  end

endmodule

// File: tb/tb_alu_result_stage.sv
// tb/tb_alu_result_stage.sv - self-checking bench for alu_result_stage (table, directed, random)
module tb_alu_result_stage;

  localparam int DEPTH = 2;
  localparam int CMAX  = 255;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_result;
  logic       in_cout;
  logic       in_ovf;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_result;
  logic [3:0] out_flags;
  logic       ovf_sticky;
  logic [7:0] ovf_count;
  logic       clr_sticky;

  alu_result_stage dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_result  (in_result),
    .in_cout    (in_cout),
    .in_ovf     (in_ovf),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_flags  (out_flags),
    .ovf_sticky (ovf_sticky),
    .ovf_count  (ovf_count),
    .clr_sticky (clr_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int res;
    int flags;
  } ent_t;

  typedef struct {
    int a;
    int b;
    int sub;
    int wrap_res;
    int wrap_flags;
    int sat_res;
    int sat_flags;
  } vec_t;

  ent_t mq[$];
  ent_t m_last;
  int   m_sticky;
  int   m_count;
  int   n_checks;
  int   n_fail;

  task automatic check_val(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_last   = '{0, 0};
    m_sticky = 0;
    m_count  = 0;
  endtask

  function automatic ent_t make_entry(input int r, input int c, input int o);
    ent_t e;
    int   v;
    v = r;
`ifdef ALU_RESULT_SAT_EN
    if (o != 0) v = (r >= 8) ? 7 : 8;
`endif
    e.res   = v;
    e.flags = ((v >= 8) ? 8 : 0) + ((v == 0) ? 4 : 0) + (o != 0 ? 2 : 0) + (c != 0 ? 1 : 0);
    return e;
  endfunction

  // 4-bit ALU computed with signed integer arithmetic.
  task automatic alu(input int a, input int b, input int sub,
                     output logic [3:0] r, output logic c, output logic o);
    int raw;
    int sa;
    int sb;
    int t;
    raw = sub ? (a + 16 - b) : (a + b);
    r   = 4'(raw % 16);
    c   = (raw >= 16);
    sa  = (a >= 8) ? a - 16 : a;
    sb  = (b >= 8) ? b - 16 : b;
    t   = sub ? sa - sb : sa + sb;
    o   = (t > 7) || (t < -8);
  endtask

  task automatic check_outputs();
    ent_t h;
    h = (mq.size() > 0) ? mq[0] : m_last;
    check_val("in_ready",   int'(in_ready),   (mq.size() < DEPTH) ? 1 : 0);
    check_val("out_valid",  int'(out_valid),  (mq.size() > 0) ? 1 : 0);
    check_val("out_result", int'(out_result), h.res);
    check_val("out_flags",  int'(out_flags),  h.flags);
    check_val("ovf_sticky", int'(ovf_sticky), m_sticky);
    check_val("ovf_count",  int'(ovf_count),  m_count);
  endtask

  // Called at a falling edge: check, drive, advance model, move to the next falling edge.
  task automatic step(input int v, input logic [3:0] r, input logic c, input logic o,
                      input int ordy, input int clr);
    bit do_push;
    bit do_pop;
    check_outputs();
    in_valid   = (v != 0);
    in_result  = r;
    in_cout    = c;
    in_ovf     = o;
    out_ready  = (ordy != 0);
    clr_sticky = (clr != 0);
    do_push = (v != 0) && (mq.size() < DEPTH);
    do_pop  = (mq.size() > 0) && (ordy != 0);
    if (do_pop) m_last = mq.pop_front();
    if (do_push) mq.push_back(make_entry(int'(r), int'(c), int'(o)));
    if (do_push && o) begin
      m_sticky = 1;
      m_count  = (clr != 0) ? 1 : ((m_count < CMAX) ? m_count + 1 : CMAX);
    end else if (clr != 0) begin
      m_sticky = 0;
      m_count  = 0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic alu_step(input int a, input int b, input int sub, input int v,
                          input int ordy, input int clr);
    logic [3:0] r;
    logic       c;
    logic       o;
    alu(a, b, sub, r, c, o);
    step(v, r, c, o, ordy, clr);
  endtask

  vec_t vecs[8];

  initial begin
    n_checks = 0;
    n_fail   = 0;
    vecs[0] = '{3, 0, 0, 4'b0011, 4'b0000, 4'b0011, 4'b0000};
    vecs[1] = '{7, 1, 0, 4'b1000, 4'b1010, 4'b0111, 4'b0010};
    vecs[2] = '{8, 8, 0, 4'b0000, 4'b0111, 4'b1000, 4'b1011};
    vecs[3] = '{5, 5, 1, 4'b0000, 4'b0101, 4'b0000, 4'b0101};
    vecs[4] = '{2, 3, 1, 4'b1111, 4'b1000, 4'b1111, 4'b1000};
    vecs[5] = '{8, 1, 1, 4'b0111, 4'b0011, 4'b1000, 4'b1011};
    vecs[6] = '{15, 1, 0, 4'b0000, 4'b0101, 4'b0000, 4'b0101};
    vecs[7] = '{6, 5, 0, 4'b1011, 4'b1010, 4'b0111, 4'b0010};

    rst_n = 1'b0;
    in_valid = 0; in_result = 0; in_cout = 0; in_ovf = 0; out_ready = 0; clr_sticky = 0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Table: push into empty, result visible one cycle later, then pop.
    for (int i = 0; i < 8; i++) begin
      alu_step(vecs[i].a, vecs[i].b, vecs[i].sub, 1, 0, 0);
`ifdef ALU_RESULT_SAT_EN
      check_val("tbl_result", int'(out_result), vecs[i].sat_res);
      check_val("tbl_flags",  int'(out_flags),  vecs[i].sat_flags);
`else
      check_val("tbl_result", int'(out_result), vecs[i].wrap_res);
      check_val("tbl_flags",  int'(out_flags),  vecs[i].wrap_flags);
`endif
      check_val("tbl_valid", int'(out_valid), 1);
      step(0, 4'd0, 1'b0, 1'b0, 1, 0);
    end
    check_val("tbl_sticky", int'(ovf_sticky), 1);
    check_val("tbl_count",  int'(ovf_count),  4);

    // Fill: third push while full must be dropped; drain keeps order.
    step(1, 4'd1, 1'b0, 1'b0, 0, 1);
    step(1, 4'd2, 1'b0, 1'b0, 0, 0);
    check_val("fill_ready", int'(in_ready), 0);
    step(1, 4'd3, 1'b0, 1'b0, 0, 0);
    check_val("fill_head", int'(out_result), 1);
    // Full with out_ready=1 and in_valid=1: pop only, then push accepted.
    step(1, 4'd4, 1'b0, 1'b0, 1, 0);
    check_val("full_pop_ready", int'(in_ready), 1);
    check_val("full_pop_head", int'(out_result), 2);
    step(1, 4'd5, 1'b0, 1'b0, 0, 0);
    check_val("full_push_ready", int'(in_ready), 0);
    step(0, 4'd0, 1'b0, 1'b0, 1, 0);
    step(0, 4'd0, 1'b0, 1'b0, 1, 0);
    check_val("drain_hold", int'(out_result), 5);
    step(0, 4'd0, 1'b0, 1'b0, 1, 0);

    // Clear colliding with an overflow push: push wins.
    alu_step(7, 1, 0, 1, 1, 0);
    alu_step(7, 1, 0, 1, 1, 1);
    check_val("clr_vs_push_sticky", int'(ovf_sticky), 1);
    check_val("clr_vs_push_count",  int'(ovf_count),  1);

    // Saturate the overflow counter.
    for (int i = 0; i < 260; i++) alu_step(7, 1, 0, 1, 1, 0);
    check_val("count_sat", int'(ovf_count), 255);
    step(0, 4'd0, 1'b0, 1'b0, 1, 1);
    step(0, 4'd0, 1'b0, 1'b0, 1, 0);
    check_val("count_clr", int'(ovf_count), 0);

    // Randomized traffic against the queue model.
    for (int i = 0; i < 400; i++) begin
      alu_step(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
               int'($urandom_range(0, 1)), int'($urandom_range(0, 3) != 0),
               int'($urandom_range(0, 2) != 0), int'($urandom_range(0, 15) == 0));
    end

    // Reset mid-traffic with a full FIFO and nonzero status.
    alu_step(7, 1, 0, 1, 0, 0);
    alu_step(2, 1, 0, 1, 0, 0);
    alu_step(4, 4, 0, 1, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    check_val("rst_out_valid", int'(out_valid), 0);
    check_val("rst_ovf_count", int'(ovf_count), 0);
    check_val("rst_sticky",    int'(ovf_sticky), 0);
    check_val("rst_result",    int'(out_result), 0);
    in_valid = 0;
    out_ready = 0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    check_val("rst_in_ready", int'(in_ready), 1);
    step(0, 4'd0, 1'b0, 1'b0, 0, 0);
    alu_step(3, 0, 0, 1, 0, 0);
    step(0, 4'd0, 1'b0, 1'b0, 1, 0);
    step(0, 4'd0, 1'b0, 1'b0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
